// File: rtl/myproject_mul_pipe_hs_if.sv
// Operand/result stream bundle for the pipelined multiplier.
// The master drives operands and out_ready; the slave (the multiplier) drives the rest.
interface myproject_mul_pipe_hs_if #(
  parameter int unsigned DIN0_WIDTH = 33,
  parameter int unsigned DIN1_WIDTH = 5,
  parameter int unsigned DOUT_WIDTH = 36
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  busy;

  modport master (
    output in_valid, din0, din1, out_ready,
    input  in_ready, out_valid, dout, busy
  );

  modport slave (
    input  in_valid, din0, din1, out_ready,
    output in_ready, out_valid, dout, busy
  );
endinterface

// File: rtl/myproject_mul_pipe_hs.sv
// Pipelined mixed-signedness integer multiplier with valid/ready handshake.
// NUM_STAGE register slices; the exact product is narrowed (wrap or saturate) into the last one.
module myproject_mul_pipe_hs #(
  parameter int unsigned DIN0_WIDTH  = 33,
  parameter int unsigned DIN1_WIDTH  = 5,
  parameter int unsigned DOUT_WIDTH  = 36,
  parameter int unsigned NUM_STAGE   = 3,
  parameter bit          DIN0_SIGNED = 1'b1,
  parameter bit          DIN1_SIGNED = 1'b0,
  parameter bit          SAT_MODE    = 1'b0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  myproject_mul_pipe_hs_if.slave bus_io
);
  localparam int unsigned PW         = DIN0_WIDTH + DIN1_WIDTH;
  localparam bit          RES_SIGNED = DIN0_SIGNED | DIN1_SIGNED;
  // Clamp bounds held one bit wider than the product so both signed and unsigned fit.
  localparam logic [PW:0] SAT_MAX_U  = {{(PW + 1 - DOUT_WIDTH){1'b0}}, {DOUT_WIDTH{1'b1}}};
  localparam logic [PW:0] SAT_MAX    = RES_SIGNED ? (SAT_MAX_U >> 1) : SAT_MAX_U;
  localparam logic [PW:0] SAT_MIN    = RES_SIGNED ? ~SAT_MAX : '0;

  logic                         en;
  logic [NUM_STAGE-1:0]         vld_q, vld_d;
  logic signed [DIN0_WIDTH:0]   a_ext;
  logic signed [DIN1_WIDTH:0]   b_ext;
  logic signed [PW-1:0]         prod;
  logic [PW-1:0]                pre_narrow;
  logic signed [PW:0]           pre_ext;
  logic [DOUT_WIDTH-1:0]        dout_d, dout_q;

  // Whole pipeline stalls only when the result slot is full and not being taken.
  assign en = ~(vld_q[NUM_STAGE-1] & ~bus_io.out_ready);

  always_comb begin
    a_ext = DIN0_SIGNED ? {bus_io.din0[DIN0_WIDTH-1], bus_io.din0} : {1'b0, bus_io.din0};
    b_ext = DIN1_SIGNED ? {bus_io.din1[DIN1_WIDTH-1], bus_io.din1} : {1'b0, bus_io.din1};
    prod  = PW'(a_ext) * PW'(b_ext);
  end

  always_comb begin
    vld_d = vld_q;
    if (en) begin
      vld_d = (vld_q << 1) | NUM_STAGE'(bus_io.in_valid);
    end
  end

  if (NUM_STAGE == 1) begin : g_single
    assign pre_narrow = prod;
  end else begin : g_multi
    logic [PW-1:0] mid_q [NUM_STAGE-1];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        for (int unsigned i = 0; i < NUM_STAGE - 1; i++) begin
          mid_q[i] <= '0;
        end
      end else if (en) begin
        mid_q[0] <= prod;
        for (int unsigned i = 1; i < NUM_STAGE - 1; i++) begin
          mid_q[i] <= mid_q[i-1];
        end
      end
    end

    assign pre_narrow = mid_q[NUM_STAGE-2];
  end

  // P is exact in PW bits under the result signedness, so one extra bit makes compares safe.
  always_comb begin
    pre_ext = RES_SIGNED ? {pre_narrow[PW-1], pre_narrow} : {1'b0, pre_narrow};
    dout_d  = pre_narrow[DOUT_WIDTH-1:0];
    if (SAT_MODE) begin
      if (pre_ext > $signed(SAT_MAX)) begin
        dout_d = SAT_MAX[DOUT_WIDTH-1:0];
      end else if (pre_ext < $signed(SAT_MIN)) begin
        dout_d = SAT_MIN[DOUT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q  <= '0;
      dout_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (en) begin
        dout_q <= dout_d;
      end
    end
  end

  assign bus_io.in_ready  = en;
  assign bus_io.out_valid = vld_q[NUM_STAGE-1];
  assign bus_io.dout      = dout_q;
  assign bus_io.busy      = |vld_q;
endmodule
